mem_arbiter: RTL and testbench

- Arbitrates between the instruction cache (read-only) and the data cache (read/write) for one single-ported RAM interface.
- Sits between the icache/dcache pair and main memory.
- Data requests have priority. A bounded-streak counter prevents instruction starvation.
- A watchdog aborts RAM accesses that hang.

---
 rtl/mem_arbiter_if.sv | 28 ++
 rtl/mem_arbiter.sv | 76 +++++++
 tb/tb_mem_arbiter.sv | 139 +++++++++++++
 3 files changed

// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if: icache/dcache request ports and single-ported RAM port of the memory arbiter
interface mem_arbiter_if #(parameter int WORD_W = 32);
    logic              iREN;
    logic [WORD_W-1:0] iaddr;
    logic              iwait;
    logic [WORD_W-1:0] iload;
    logic              dREN;
    logic              dWEN;
    logic [WORD_W-1:0] daddr;
    logic [WORD_W-1:0] dstore;
    logic              dwait;
    logic [WORD_W-1:0] dload;
    logic              ramREN;
    logic              ramWEN;
    logic [WORD_W-1:0] ramaddr;
    logic [WORD_W-1:0] ramstore;
    logic [WORD_W-1:0] ramload;
    logic              ram_ready;
    logic              err;
    modport master (
        input  iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ram_ready,
        output iwait, iload, dwait, dload, ramREN, ramWEN, ramaddr, ramstore, err
    );
    modport slave (
        output iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ram_ready,
        input  iwait, iload, dwait, dload, ramREN, ramWEN, ramaddr, ramstore, err
    );
endinterface

// File: rtl/mem_arbiter.sv
// mem_arbiter: data-priority icache/dcache arbiter for one RAM port, with a bounded
// data streak so instruction fetches cannot starve, and a watchdog on hung accesses.
module mem_arbiter #(
    parameter int WORD_W      = 32,
    parameter int MAX_DSTREAK = 4,
    parameter int TIMEOUT     = 255
) (
    input logic           CLK,
    input logic           nRST,
    mem_arbiter_if.master bus
);
    localparam int SW = $clog2(MAX_DSTREAK + 1);
    localparam int TW = $clog2(TIMEOUT + 1);
    typedef enum logic [1:0] {IDLE, I_ACC, D_ACC, GAP} state_t;
    state_t        state, next;
    logic [SW-1:0] dstreak, dstreak_n;
    logic [TW-1:0] timer, timer_n;
    logic          err_q, err_n;
    logic          ireq, dreq, acc, req, done, drop, tout, sat;
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state   <= IDLE;
            dstreak <= '0;
            timer   <= '0;
            err_q   <= 1'b0;
        end else begin
            state   <= next;
            dstreak <= dstreak_n;
            timer   <= timer_n;
            err_q   <= err_n;
        end
    end
    always_comb begin
        ireq = bus.iREN;
        dreq = bus.dREN | bus.dWEN;
        sat  = dstreak == SW'(MAX_DSTREAK);
        acc  = state == I_ACC || state == D_ACC;
        req  = state == I_ACC ? ireq : dreq;
        drop = acc && !req;
        done = acc && req && bus.ram_ready;
        tout = acc && req && !bus.ram_ready && timer == TW'(TIMEOUT - 1);
        next      = state;
        dstreak_n = dstreak;
        timer_n   = '0;
        err_n     = 1'b0;
        case (state)
            IDLE:    next = dreq && !(ireq && sat) ? D_ACC : ireq ? I_ACC : IDLE;
            GAP:     next = IDLE;
            default: begin
                if (drop) begin
                    next = IDLE;
                end else if (done) begin
                    next = GAP;
                    // Only a data grant that made an instruction fetch wait extends the streak
                    dstreak_n = state == I_ACC || !ireq ? '0 : sat ? dstreak : dstreak + 1'b1;
                end else if (tout) begin
                    next  = IDLE;
                    err_n = 1'b1;
                end else begin
                    timer_n = timer + 1'b1;
                end
            end
        endcase
    end
    always_comb begin
        bus.ramREN   = state == I_ACC || (state == D_ACC && !bus.dWEN);
        bus.ramWEN   = state == D_ACC && bus.dWEN;
        bus.ramaddr  = state == I_ACC ? bus.iaddr : state == D_ACC ? bus.daddr : '0;
        bus.ramstore = state == D_ACC ? bus.dstore : '0;
        bus.iwait    = !(done && state == I_ACC);
        bus.dwait    = !(done && state == D_ACC);
        bus.iload    = done && state == I_ACC ? bus.ramload : '0;
        bus.dload    = done && state == D_ACC ? bus.ramload : '0;
        bus.err      = err_q;
    end
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed cycle vectors plus hand-written streak, watchdog and async-reset sequences
module tb_mem_arbiter;
    localparam logic [31:0] IA = 32'h100, DA = 32'h200, DS = 32'h1234_5678;
    localparam logic [132:0] IDLE_O = {5'b11000, 128'b0};
    typedef struct {
        logic ir, dr, dw, rdy;
        logic [31:0] ld;
        logic iw, dwt, ren, wen;
        logic [31:0] addr, store, il, dl;
    } vec_t;
    logic CLK = 1'b0;
    logic nRST = 1'b0;
    int tests = 0;
    int fails = 0;
    vec_t tbl[$];
    always #5 CLK = ~CLK;
    mem_arbiter_if #(.WORD_W(32)) bus();
    mem_arbiter #(.WORD_W(32), .MAX_DSTREAK(4), .TIMEOUT(8)) dut (.CLK(CLK), .nRST(nRST), .bus(bus));
    function automatic logic [132:0] outs();
        return {bus.iwait, bus.dwait, bus.ramREN, bus.ramWEN, bus.err,
                bus.ramaddr, bus.ramstore, bus.iload, bus.dload};
    endfunction
    task automatic check(input string name, input logic [132:0] act, input logic [132:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask
    task automatic drive(input logic ir, dr, dw, rdy, input logic [31:0] ld);
        bus.iREN = ir; bus.dREN = dr; bus.dWEN = dw; bus.ram_ready = rdy; bus.ramload = ld;
    endtask
    task automatic add(input logic ir, dr, dw, rdy, input logic [31:0] ld,
                       input logic iw, dwt, ren, wen, input logic [31:0] addr, store, il, dl);
        tbl.push_back('{ir, dr, dw, rdy, ld, iw, dwt, ren, wen, addr, store, il, dl});
    endtask
    task automatic do_reset(input string name);
        nRST = 1'b0;
        drive(0, 0, 0, 0, 0);
        @(negedge CLK);
        #1 check(name, outs(), IDLE_O);
        nRST = 1'b1;
    endtask
    initial begin
        string s;
        logic [18:0] errm, renm;
        logic dw_ok;
        bus.iaddr = IA; bus.daddr = DA; bus.dstore = DS;
        // single I read, ready on third ACC cycle
        add(1,0,0,0,0,            1,1,0,0,0,0,0,0);
        add(1,0,0,0,0,            1,1,1,0,IA,0,0,0);
        add(1,0,0,0,32'h1111,     1,1,1,0,IA,0,0,0);
        add(1,0,0,1,32'hDEADBEEF, 0,1,1,0,IA,0,32'hDEADBEEF,0);
        add(0,0,0,0,0,            1,1,0,0,0,0,0,0);
        add(0,0,0,0,0,            1,1,0,0,0,0,0,0);
        // simultaneous I + D write: D first, I after the gap
        add(1,0,1,0,0,            1,1,0,0,0,0,0,0);
        add(1,0,1,0,32'h2222,     1,1,0,1,DA,DS,0,0);
        add(1,0,1,1,0,            1,0,0,1,DA,DS,0,0);
        add(1,0,0,0,0,            1,1,0,0,0,0,0,0);
        add(1,0,0,0,0,            1,1,0,0,0,0,0,0);
        add(1,0,0,1,32'h55,       0,1,1,0,IA,0,32'h55,0);
        add(0,0,0,0,0,            1,1,0,0,0,0,0,0);
        // dREN and dWEN together: write wins
        add(0,1,1,0,0,            1,1,0,0,0,0,0,0);
        add(0,1,1,0,0,            1,1,0,1,DA,DS,0,0);
        add(0,1,1,1,0,            1,0,0,1,DA,DS,0,0);
        add(0,0,0,0,0,            1,1,0,0,0,0,0,0);
        // D read
        add(0,1,0,0,0,            1,1,0,0,0,0,0,0);
        add(0,1,0,1,32'hCAFEF00D, 1,0,1,0,DA,DS,0,32'hCAFEF00D);
        add(0,0,0,0,0,            1,1,0,0,0,0,0,0);
        // I drops mid-access: straight back to IDLE, no gap
        add(1,0,0,0,0,            1,1,0,0,0,0,0,0);
        add(0,0,0,0,0,            1,1,1,0,IA,0,0,0);
        add(0,1,0,0,0,            1,1,0,0,0,0,0,0);
        add(0,1,0,0,0,            1,1,1,0,DA,DS,0,0);
        add(0,1,0,1,32'h77,       1,0,1,0,DA,DS,0,32'h77);
        add(0,0,0,0,0,            1,1,0,0,0,0,0,0);
        do_reset("reset_vec");
        foreach (tbl[i]) begin
            drive(tbl[i].ir, tbl[i].dr, tbl[i].dw, tbl[i].rdy, tbl[i].ld);
            #1 check($sformatf("vec%0d", i), outs(),
                     {tbl[i].iw, tbl[i].dwt, tbl[i].ren, tbl[i].wen, 1'b0,
                      tbl[i].addr, tbl[i].store, tbl[i].il, tbl[i].dl});
            @(negedge CLK);
        end
        // starvation bound: both requesters held, RAM always ready
        do_reset("reset_streak");
        drive(1, 1, 0, 1, 0);
        s = "";
        for (int c = 0; c < 60 && s.len() < 10; c++) begin
            @(negedge CLK);
            #1;
            if (!bus.dwait) s = {s, "D"};
            if (!bus.iwait) s = {s, "I"};
        end
        tests++;
        if (s != "DDDDIDDDDI") begin
            fails++;
            $display("FAIL streak_order: got %s, expected DDDDIDDDDI", s);
        end
        // watchdog: D granted, RAM never ready
        do_reset("reset_wdog");
        drive(0, 1, 0, 0, 0);
        errm = '0; renm = '0; dw_ok = 1'b1;
        for (int c = 0; c < 19; c++) begin
            if (c > 0) begin
                @(negedge CLK);
                #1;
            end
            errm[c] = bus.err;
            renm[c] = bus.ramREN;
            if (!bus.dwait) dw_ok = 1'b0;
        end
        check("wdog_err_cycles", 133'(errm), 133'(19'b100_0000_0010_0000_0000));
        check("wdog_ren_cycles", 133'(renm), 133'(19'b011_1111_1101_1111_1110));
        check("wdog_dwait_held", 133'(dw_ok), 133'(1'b1));
        // async reset in the middle of a D write
        do_reset("reset_async");
        drive(0, 0, 1, 0, 0);
        @(negedge CLK);
        #1 check("async_pre", 133'({bus.ramWEN, bus.dwait}), 133'(2'b11));
        #2 nRST = 1'b0;
        #1 check("async_drop", 133'({bus.ramWEN, bus.dwait}), 133'(2'b01));
        drive(0, 0, 0, 0, 0);
        @(negedge CLK);
        nRST = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge CLK);
            #1 check($sformatf("async_idle%0d", c), outs(), IDLE_O);
        end
        drive(1, 0, 0, 0, 0);
        @(negedge CLK);
        #1 check("async_then_i", outs(), {5'b11100, IA, 96'b0});
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
